// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding 128-bit cacheline memory controller with fixed response latency.
// Define MEM_CTRL_RANGE_ERR_EN to add rsp_err and reject out-of-range line addresses.
module mem_ctrl #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_LINES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [19:0]  req_addr,
  input  logic [127:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [127:0] rsp_data
`ifdef MEM_CTRL_RANGE_ERR_EN
  ,
  output logic         rsp_err
`endif
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

  typedef logic [LINE_W-1:0] cacheline_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  cacheline_t       data_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_write_q;
  cacheline_t       rsp_data_q;
  cacheline_t       mem_q [DEPTH_LINES];

  logic accept_c;
  logic commit_c;
  logic mem_we_c;
  logic oor_c;
  logic addr_unused_c;

  assign accept_c = req_valid && req_ready_q;
  assign commit_c = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we_c = commit_c && wr_q && !err_q;

  // Offset bits and, when wrapping, the upper index bits carry no meaning.
  assign addr_unused_c = ^req_addr;

`ifdef MEM_CTRL_RANGE_ERR_EN
  assign oor_c = {1'b0, req_addr[19:4]} >= 17'(DEPTH_LINES);
`else
  assign oor_c = 1'b0;
`endif

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q     <= BUSY;
            cnt_q       <= CNT_W'(LATENCY - 1);
            wr_q        <= req_write;
            err_q       <= oor_c;
            idx_q       <= req_addr[4 +: IDX_W];
            data_q      <= req_data;
            req_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= wr_q;
            rsp_data_q  <= (wr_q || err_q) ? '0 : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; an aborted request never reaches the commit cycle.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_q] <= data_q;
    end
  end

`ifdef MEM_CTRL_RANGE_ERR_EN
  logic rsp_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (commit_c) begin
      rsp_err_q <= err_q;
    end
  end

  assign rsp_err = rsp_err_q;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic against a line-array model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [127:0] rsp_data;

  logic         b_req_valid, b_req_ready, b_req_write;
  logic [19:0]  b_req_addr;
  logic [127:0] b_req_data;
  logic         b_rsp_valid, b_rsp_ready, b_rsp_write;
  logic [127:0] b_rsp_data;
`ifdef MEM_CTRL_RANGE_ERR_EN
  logic         rsp_err, b_rsp_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] model_mem [int unsigned];

  always #5 clk = ~clk;

  mem_ctrl #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data)
`ifdef MEM_CTRL_RANGE_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  mem_ctrl #(.LATENCY(1), .DEPTH_LINES(DEPTH)) u_b2b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_write(b_rsp_write),
    .rsp_data(b_rsp_data)
`ifdef MEM_CTRL_RANGE_ERR_EN
    , .rsp_err(b_rsp_err)
`endif
  );

  function automatic int unsigned line_of(input logic [19:0] a);
    return (int'(a) / 16) % DEPTH;
  endfunction

  function automatic bit out_of_range(input logic [19:0] a);
`ifdef MEM_CTRL_RANGE_ERR_EN
    return (int'(a) / 16) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble_req();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = 20'($urandom);
    req_data  = rand_line();
  endtask

  // One full transaction on u_dut: accept, latency, optional stall, handshake.
  task automatic run_txn(input logic wr, input logic [19:0] addr, input logic [127:0] data,
                         input int stall, input string tag);
    logic [127:0] exp_data;
    logic [127:0] held;
    bit           known;
    bit           exp_err;
    int unsigned  ln;
    int           cyc;
    ln      = line_of(addr);
    exp_err = out_of_range(addr);
    known   = 1'b1;
    if (wr || exp_err) exp_data = '0;
    else if (model_mem.exists(ln)) exp_data = model_mem[ln];
    else begin exp_data = '0; known = 1'b0; end

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = data; rsp_ready = 1'b0;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s accept: req_ready=%b required 1", tag, req_ready); return;
    end
    @(posedge clk); #1;

    cyc = 0;
    do begin
      n_vec++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy: req_ready=%b rsp_valid=%b required 0/0", tag, req_ready, rsp_valid);
      end
      scramble_req();
      rsp_ready = 1'($urandom);
      @(posedge clk); #1; cyc++;
    end while (rsp_valid !== 1'b1 && cyc < 40);
    rsp_ready = 1'b0;

    n_vec++;
    if (cyc != int'(LAT) || rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL %s latency: got %0d cycles required %0d", tag, cyc, LAT); return;
    end
    n_vec++;
    if (rsp_write !== wr) begin
      n_err++; $display("FAIL %s rsp_write: got %b required %b", tag, rsp_write, wr);
    end
    if (known) begin
      n_vec++;
      if (rsp_data !== exp_data) begin
        n_err++; $display("FAIL %s rsp_data: got %h required %h", tag, rsp_data, exp_data);
      end
    end
`ifdef MEM_CTRL_RANGE_ERR_EN
    n_vec++;
    if (rsp_err !== exp_err) begin
      n_err++; $display("FAIL %s rsp_err: got %b required %b", tag, rsp_err, exp_err);
    end
`endif
    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      scramble_req();
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_write !== wr || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s stall%0d: valid=%b ready=%b write=%b data=%h required 1/0/%b/%h",
                 tag, s, rsp_valid, req_ready, rsp_write, rsp_data, wr, held);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s handshake: rsp_valid=%b req_ready=%b required 0/1", tag, rsp_valid, req_ready);
    end
    if (wr && !exp_err) model_mem[ln] = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_data !== '0) begin
      n_err++;
      $display("FAIL %s: req_ready=%b rsp_valid=%b rsp_write=%b rsp_data=%h required 1/0/0/0",
               tag, req_ready, rsp_valid, rsp_write, rsp_data);
    end
`ifdef MEM_CTRL_RANGE_ERR_EN
    n_vec++;
    if (rsp_err !== 1'b0) begin
      n_err++; $display("FAIL %s rsp_err: got %b required 0", tag, rsp_err);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_data = '0; b_rsp_ready = 1'b1;
    #3;
    check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset_release");
  endtask

  task automatic test_write_fill();
    logic [127:0] pat;
    pat = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
    run_txn(1'b1, 20'h00120, pat, 0, "wb_00120");
    run_txn(1'b0, 20'h00120, rand_line(), 0, "fill_00120");
  endtask

  task automatic test_offset();
    run_txn(1'b1, 20'h00125, rand_line(), 0, "wb_00125");
    run_txn(1'b0, 20'h00120, rand_line(), 0, "fill_00120_ofs");
    run_txn(1'b0, 20'h0012F, rand_line(), 1, "fill_0012f_ofs");
  endtask

  task automatic test_stall();
    run_txn(1'b0, 20'h00120, rand_line(), 6, "fill_stall6");
  endtask

  task automatic test_range();
    run_txn(1'b1, 20'h00010, rand_line(), 0, "wb_00010");
    run_txn(1'b0, 20'h40010, rand_line(), 0, "fill_40010");
    run_txn(1'b1, 20'h40010, rand_line(), 0, "wb_40010");
    run_txn(1'b0, 20'h00010, rand_line(), 0, "fill_00010");
  endtask

  task automatic test_reset_abort();
    logic [127:0] old_line;
    old_line = rand_line();
    run_txn(1'b1, 20'h00300, old_line, 0, "wb_00300_pre");
    run_txn(1'b0, 20'h00300, rand_line(), 0, "fill_00300_pre");
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_idle: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00300; req_data = ~old_line;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check_reset_outputs("abort_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    run_txn(1'b0, 20'h00300, rand_line(), 0, "fill_00300_post");
  endtask

  task automatic test_random();
    logic [19:0] a;
    for (int i = 0; i < 40; i++) begin
      a = {(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0), 10'($urandom_range(0, 7)), 4'($urandom)};
      run_txn(1'($urandom), a, rand_line(), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    bit exp_ready, exp_valid;
    b_req_write = 1'b1; b_req_addr = 20'h00450; b_req_data = rand_line(); b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_ready = (i % 3 == 0);
      exp_valid = (i % 3 == 2);
      n_vec++;
      if (b_req_ready !== exp_ready || b_rsp_valid !== exp_valid) begin
        n_err++;
        $display("FAIL b2b cycle%0d: req_ready=%b rsp_valid=%b required %b/%b",
                 i, b_req_ready, b_rsp_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        n_vec++;
        if (b_rsp_write !== 1'b1 || b_rsp_data !== '0) begin
          n_err++;
          $display("FAIL b2b rsp cycle%0d: write=%b data=%h required 1/0", i, b_rsp_write, b_rsp_data);
        end
      end
      b_req_data = rand_line();
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_fill();
    test_offset();
    test_stall();
    test_range();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to response; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LINES, default 1024: number of 128-bit cachelines stored; power of two, at most 65536.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: cache presents a line request.
REQ-006 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = line writeback, 0 = line fill.
REQ-008 SHALL have port req_addr, input, 20 bits: physical pointer (pptr_t); bits [3:0] are ignored.
REQ-009 SHALL have port req_data, input, 128 bits: writeback line (cacheline_t); ignored on fills.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: cache consumes the response.
REQ-012 SHALL have port rsp_write, output, 1 bit: echo of the captured req_write.
REQ-013 SHALL have port rsp_data, output, 128 bits: fill data; all zeros for writebacks.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL take the IDLE->BUSY transition on a clock edge where req_valid and req_ready are both 1, capturing write, address line index and data, and loading the counter with LATENCY-1.
REQ-017 SHALL, in BUSY, decrement the counter each cycle; when the counter is 0, it SHALL perform the array access (write req_data, or read into the response register) and go to RESP.
REQ-018 SHALL raise rsp_valid exactly LATENCY cycles after the accepting edge (LATENCY=1: rsp_valid high in the cycle right after acceptance).
REQ-019 SHALL hold rsp_valid, rsp_write and rsp_data stable in RESP until a cycle with rsp_ready=1, then go to IDLE on that edge.
REQ-020 SHALL allow no back-to-back overlap: at most one outstanding request; a new request is accepted at the earliest in the cycle after the response handshake.
REQ-021 SHALL form the line index from req_addr[4+log2(DEPTH_LINES)-1:4].
REQ-022 SHALL return the previously written value when a fill follows a writeback to the same line.
REQ-023 SHALL ignore req_valid outside IDLE; input changes during BUSY/RESP SHALL have no effect.

Reset
REQ-024 SHALL, while reset=1, force state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_write=0 and rsp_data=0, asynchronously.
REQ-025 SHALL abort an in-flight request on reset mid-BUSY: a writeback not yet committed (counter not yet 0) SHALL NOT modify the array, and no response is produced.
REQ-026 SHALL leave array contents unchanged by reset; never-written lines read as undefined.

Configuration
REQ-027 SHALL, with MEM_CTRL_RANGE_ERR_EN defined, add output rsp_err (1 bit, reset 0); a request with req_addr[19:4] >= DEPTH_LINES SHALL complete with normal latency, rsp_err=1, rsp_data=0 and no array write.
REQ-028 SHALL, without MEM_CTRL_RANGE_ERR_EN, omit the rsp_err port and silently wrap out-of-range addresses by discarding the upper index bits.

Verification
REQ-029 SHALL cover: LATENCY=4, write addr 0x00120 data 0xDEADBEEF_..._0001 -> rsp_valid 4 cycles after acceptance, rsp_write=1, rsp_data=0; then fill 0x00120 -> rsp_data=0xDEADBEEF_..._0001.
REQ-030 SHALL cover: fill with rsp_ready held 0 for 6 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, IDLE on the 7th-cycle handshake.
REQ-031 SHALL cover: req_addr 0x00125 vs 0x00120 -> same line; offset bits ignored.
REQ-032 SHALL cover: reset asserted 2 cycles into a writeback to 0x00300 -> outputs at reset values immediately; a later fill returns the pre-write contents.
REQ-033 SHALL cover: DEPTH_LINES=1024, addr 0x40010, macro on -> rsp_err=1, rsp_data=0; macro off -> aliases line 0x001.
REQ-034 SHALL cover: LATENCY=1, req_valid held high with rsp_ready=1 -> one acceptance every 3 cycles.
